// File: rtl/apb_cmd_master.sv
// APB master: turns a valid/ready command stream into APB SETUP/ACCESS
// transfers with slave decode, wait states, PSLVERR capture and a bounded
// ACCESS timeout, and returns a valid/ready response.
module apb_cmd_master #(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned NUM_SLV = 1,
  parameter int unsigned SLV_LSB = 10,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic               PCLK,
  input  logic               PRESET,
  // command stream
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_write,
  input  logic [ADDR_W-1:0]  cmd_addr,
  input  logic [DATA_W-1:0]  cmd_wdata,
  // response stream
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DATA_W-1:0]  rsp_rdata,
  output logic               rsp_err,
  output logic               rsp_timeout,
  // APB
  output logic [ADDR_W-1:0]  PADDR,
  output logic               PWRITE,
  output logic [NUM_SLV-1:0] PSEL,
  output logic               PENABLE,
  output logic [DATA_W-1:0]  PWDATA,
  input  logic [DATA_W-1:0]  PRDATA,
  input  logic               PREADY,
  input  logic               PSLVERR
);

  localparam int unsigned SEL_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               cmd_ready_d;
  logic               rsp_valid_d;
  logic [DATA_W-1:0]  rsp_rdata_d;
  logic               rsp_err_d;
  logic               rsp_timeout_d;
  logic [ADDR_W-1:0]  paddr_d;
  logic               pwrite_d;
  logic [NUM_SLV-1:0] psel_d;
  logic               penable_d;
  logic [DATA_W-1:0]  pwdata_d;

  // Slave decode and word-aligned address of the offered command
  logic [SEL_W-1:0]   sel_c;
  logic               dec_err_c;
  logic [NUM_SLV-1:0] psel_dec_c;
  logic [ADDR_W-1:0]  paddr_c;

  assign sel_c      = cmd_addr[SLV_LSB +: SEL_W];
  assign dec_err_c  = (32'(sel_c) >= NUM_SLV);
  assign psel_dec_c = NUM_SLV'(1) << sel_c;
  assign paddr_c    = cmd_addr & ~ADDR_W'(3);

  // Next state and next values of every registered output
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    cmd_ready_d   = cmd_ready;
    rsp_valid_d   = rsp_valid;
    rsp_rdata_d   = rsp_rdata;
    rsp_err_d     = rsp_err;
    rsp_timeout_d = rsp_timeout;
    paddr_d       = PADDR;
    pwrite_d      = PWRITE;
    psel_d        = PSEL;
    penable_d     = PENABLE;
    pwdata_d      = PWDATA;

    case (state_q)
      ST_IDLE: begin
        cmd_ready_d = 1'b1;
        psel_d      = '0;
        penable_d   = 1'b0;
        paddr_d     = '0;
        pwrite_d    = 1'b0;
        pwdata_d    = '0;
        if (cmd_valid && cmd_ready) begin
          cmd_ready_d = 1'b0;
          if (dec_err_c) begin
            // Unmapped slave: answer with an error, no bus activity
            state_d       = ST_RESP;
            rsp_valid_d   = 1'b1;
            rsp_err_d     = 1'b1;
            rsp_timeout_d = 1'b0;
            rsp_rdata_d   = '0;
          end else begin
            state_d  = ST_SETUP;
            cnt_d    = '0;
            psel_d   = psel_dec_c;
            paddr_d  = paddr_c;
            pwrite_d = cmd_write;
            pwdata_d = cmd_write ? cmd_wdata : '0;
          end
        end
      end

      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
      end

      ST_ACCESS: begin
        if (PREADY) begin
          // PSLVERR only counts in the completing cycle
          state_d       = ST_RESP;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = PSLVERR;
          rsp_timeout_d = 1'b0;
          rsp_rdata_d   = (!PWRITE && !PSLVERR) ? PRDATA : '0;
          psel_d        = '0;
          penable_d     = 1'b0;
          paddr_d       = '0;
          pwrite_d      = 1'b0;
          pwdata_d      = '0;
        end else if (cnt_q == CNT_LAST) begin
          // Last allowed ACCESS cycle without PREADY: abort the transfer
          state_d       = ST_RESP;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_rdata_d   = '0;
          psel_d        = '0;
          penable_d     = 1'b0;
          paddr_d       = '0;
          pwrite_d      = 1'b0;
          pwdata_d      = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          state_d       = ST_IDLE;
          cmd_ready_d   = 1'b1;
          rsp_valid_d   = 1'b0;
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b0;
          rsp_timeout_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, wait counter and output registers with synchronous reset
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      cmd_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      PADDR       <= '0;
      PWRITE      <= 1'b0;
      PSEL        <= '0;
      PENABLE     <= 1'b0;
      PWDATA      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_ready   <= cmd_ready_d;
      rsp_valid   <= rsp_valid_d;
      rsp_rdata   <= rsp_rdata_d;
      rsp_err     <= rsp_err_d;
      rsp_timeout <= rsp_timeout_d;
      PADDR       <= paddr_d;
      PWRITE      <= pwrite_d;
      PSEL        <= psel_d;
      PENABLE     <= penable_d;
      PWDATA      <= pwdata_d;
    end
  end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Bench for apb_cmd_master: directed scenarios plus randomized transfers
// checked against a transaction-level expectation model.
module tb_apb_cmd_master;

  localparam int unsigned ADDR_W  = 12;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned NUM_SLV = 3;
  localparam int unsigned SLV_LSB = 10;
  localparam int unsigned TIMEOUT = 16;

  logic               PCLK = 1'b0;
  logic               PRESET;
  logic               cmd_valid;
  logic               cmd_ready;
  logic               cmd_write;
  logic [ADDR_W-1:0]  cmd_addr;
  logic [DATA_W-1:0]  cmd_wdata;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [DATA_W-1:0]  rsp_rdata;
  logic               rsp_err;
  logic               rsp_timeout;
  logic [ADDR_W-1:0]  PADDR;
  logic               PWRITE;
  logic [NUM_SLV-1:0] PSEL;
  logic               PENABLE;
  logic [DATA_W-1:0]  PWDATA;
  logic [DATA_W-1:0]  PRDATA;
  logic               PREADY;
  logic               PSLVERR;

  int checks = 0;
  int passed = 0;

  apb_cmd_master #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .NUM_SLV(NUM_SLV),
    .SLV_LSB(SLV_LSB),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .PCLK       (PCLK),
    .PRESET     (PRESET),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .rsp_timeout(rsp_timeout),
    .PADDR      (PADDR),
    .PWRITE     (PWRITE),
    .PSEL       (PSEL),
    .PENABLE    (PENABLE),
    .PWDATA     (PWDATA),
    .PRDATA     (PRDATA),
    .PREADY     (PREADY),
    .PSLVERR    (PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d passed %0d", checks, passed);
    $fatal(1, "watchdog");
  end

  // Transaction-level expectation: what a complete transfer should look like
  task automatic model(input logic wr, input logic [11:0] addr, input logic [15:0] wd,
                       input int waits, input logic slverr, input logic [15:0] rd,
                       output logic dec, output int acc, output int lat,
                       output logic [2:0] psel, output logic [11:0] paddr,
                       output logic [15:0] pwdata, output logic err,
                       output logic tmo, output logic [15:0] rdata);
    int sel;
    sel = (int'(addr) / 1024) % 4;
    dec = (sel >= int'(NUM_SLV));
    if (dec) begin
      acc = 0; lat = 1; psel = '0; paddr = '0; pwdata = '0;
      err = 1'b1; tmo = 1'b0; rdata = '0;
    end else begin
      tmo    = (waits >= int'(TIMEOUT));
      acc    = tmo ? int'(TIMEOUT) : waits + 1;
      lat    = 2 + acc;
      psel   = 3'(1 << sel);
      paddr  = 12'((int'(addr) / 4) * 4);
      pwdata = wr ? wd : 16'h0;
      err    = tmo || slverr;
      rdata  = (!wr && !err) ? rd : 16'h0;
    end
  endtask

  // One full command/response transfer with the bench acting as APB slave
  task automatic do_txn(input string nm, input logic wr, input logic [11:0] addr,
                        input logic [15:0] wd, input int waits, input logic slverr,
                        input logic [15:0] rd, input int hold);
    logic dec, e_err, e_tmo;
    int e_acc, e_lat;
    logic [2:0] e_psel;
    logic [11:0] e_paddr;
    logic [15:0] e_pwdata, e_rdata;
    int setup_n, acc_n, lat;
    bit got, bus_ok, hold_ok;
    logic s_err, s_tmo;
    logic [15:0] s_rdata;

    model(wr, addr, wd, waits, slverr, rd, dec, e_acc, e_lat, e_psel, e_paddr,
          e_pwdata, e_err, e_tmo, e_rdata);

    got = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge PCLK);
      if (cmd_ready === 1'b1) begin got = 1; break; end
    end
    checks++;
    if (!got) begin
      $display("FAIL %s cmd_ready: got %b want 1 within 10 cycles", nm, cmd_ready);
      return;
    end else passed++;

    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
    @(posedge PCLK);
    setup_n = 0; acc_n = 0; lat = 0; got = 0; bus_ok = 1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge PCLK);
      if (c == 1) begin
        cmd_valid = 1'b0; cmd_write = 1'($urandom);
        cmd_addr = 12'($urandom); cmd_wdata = 16'($urandom);
      end
      if (rsp_valid === 1'b1) begin lat = c; got = 1; break; end
      if (cmd_ready !== 1'b0) bus_ok = 0;
      if (PSEL !== '0) begin
        if (PSEL !== e_psel || PADDR !== e_paddr || PWDATA !== e_pwdata || PWRITE !== wr)
          bus_ok = 0;
        if (PENABLE === 1'b1) acc_n++;
        else begin
          setup_n++;
          if (acc_n != 0) bus_ok = 0;
        end
      end else if (PENABLE !== 1'b0 || PADDR !== '0 || PWDATA !== '0) bus_ok = 0;
      if (PSEL !== '0 && PENABLE === 1'b1) begin
        if (acc_n == waits + 1) begin
          PREADY = 1'b1; PRDATA = rd; PSLVERR = slverr;
        end else begin
          PREADY = 1'b0; PRDATA = 16'($urandom); PSLVERR = 1'($urandom);
        end
      end else begin
        PREADY = 1'($urandom); PRDATA = 16'($urandom); PSLVERR = 1'($urandom);
      end
    end
    PREADY = 1'b0; PSLVERR = 1'b0;

    checks++;
    if (!got) begin
      $display("FAIL %s rsp_valid: never seen within 60 cycles, want after %0d", nm, e_lat);
      return;
    end else passed++;

    checks++;
    if (setup_n !== (dec ? 0 : 1)) $display("FAIL %s setup_cycles: got %0d want %0d", nm, setup_n, dec ? 0 : 1);
    else passed++;
    checks++;
    if (acc_n !== e_acc) $display("FAIL %s access_cycles: got %0d want %0d", nm, acc_n, e_acc);
    else passed++;
    checks++;
    if (!bus_ok) $display("FAIL %s bus_values: PSEL/PADDR/PWDATA/PWRITE/cmd_ready wrong during transfer (want psel %h paddr %h pwdata %h)", nm, e_psel, e_paddr, e_pwdata);
    else passed++;
    checks++;
    if (lat !== e_lat) $display("FAIL %s rsp_latency: got %0d want %0d", nm, lat, e_lat);
    else passed++;
    checks++;
    if ({rsp_err, rsp_timeout} !== {e_err, e_tmo})
      $display("FAIL %s rsp_err/timeout: got %b%b want %b%b", nm, rsp_err, rsp_timeout, e_err, e_tmo);
    else passed++;
    checks++;
    if (rsp_rdata !== e_rdata) $display("FAIL %s rsp_rdata: got %h want %h", nm, rsp_rdata, e_rdata);
    else passed++;

    s_err = rsp_err; s_tmo = rsp_timeout; s_rdata = rsp_rdata; hold_ok = 1;
    for (int i = 0; i < hold; i++) begin
      @(negedge PCLK);
      if (rsp_valid !== 1'b1 || rsp_err !== s_err || rsp_timeout !== s_tmo ||
          rsp_rdata !== s_rdata || cmd_ready !== 1'b0 || PSEL !== '0 || PENABLE !== 1'b0)
        hold_ok = 0;
    end
    checks++;
    if (!hold_ok) $display("FAIL %s rsp_hold: response not stable or cmd_ready high over %0d stalled cycles", nm, hold);
    else passed++;

    rsp_ready = 1'b1;
    @(negedge PCLK);
    rsp_ready = 1'b0;
    checks++;
    if ({rsp_valid, rsp_err, rsp_timeout, rsp_rdata, cmd_ready, PSEL, PENABLE} !== {1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 3'b0, 1'b0})
      $display("FAIL %s after_handshake: got valid %b err %b tmo %b rdata %h ready %b psel %b pen %b want 0 0 0 0000 1 000 0",
               nm, rsp_valid, rsp_err, rsp_timeout, rsp_rdata, cmd_ready, PSEL, PENABLE);
    else passed++;
  endtask

  task automatic test_reset();
    PRESET = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge PCLK);
      cmd_valid = 1'($urandom); cmd_write = 1'($urandom); cmd_addr = 12'($urandom);
      cmd_wdata = 16'($urandom); rsp_ready = 1'($urandom); PREADY = 1'($urandom);
      PRDATA = 16'($urandom); PSLVERR = 1'($urandom);
    end
    @(negedge PCLK);
    checks++;
    if ({cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, PADDR, PWRITE, PSEL, PENABLE, PWDATA} !== 53'h0)
      $display("FAIL reset_outputs: got %h want 0", {cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, PADDR, PWRITE, PSEL, PENABLE, PWDATA});
    else passed++;
    cmd_valid = 1'b0; rsp_ready = 1'b0; PREADY = 1'b0; PSLVERR = 1'b0;
    PRESET = 1'b0;
    @(negedge PCLK);
    checks++;
    if ({cmd_ready, rsp_valid, PSEL, PENABLE} !== 6'b100000)
      $display("FAIL reset_release: got ready %b valid %b psel %b pen %b want 1 0 000 0", cmd_ready, rsp_valid, PSEL, PENABLE);
    else passed++;
  endtask

  task automatic test_write_basic();
    do_txn("write_basic", 1'b1, 12'h004, 16'hA5C3, 0, 1'b0, 16'hBEEF, 0);
  endtask

  task automatic test_read_wait();
    do_txn("read_wait3", 1'b0, 12'h00C, 16'h0000, 3, 1'b0, 16'h1234, 1);
  endtask

  task automatic test_timeout();
    do_txn("timeout", 1'b1, 12'h008, 16'h5A5A, 1000, 1'b0, 16'h0, 0);
    do_txn("ready_last_cycle", 1'b0, 12'h410, 16'h0, int'(TIMEOUT) - 1, 1'b0, 16'hC0DE, 0);
  endtask

  task automatic test_decode_err();
    do_txn("decode_err", 1'b1, 12'hC00, 16'h1111, 0, 1'b0, 16'h0, 0);
  endtask

  task automatic test_pslverr();
    do_txn("pslverr_read", 1'b0, 12'h814, 16'h0, 2, 1'b1, 16'h7777, 5);
  endtask

  task automatic test_back_to_back();
    int acc_q[$];
    int rsps;
    bit spacing_ok;
    rsps = 0;
    @(negedge PCLK);
    rsp_ready = 1'b1; PREADY = 1'b1; PSLVERR = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 12'h010; cmd_wdata = 16'h0F0F;
    for (int c = 0; c < 40; c++) begin
      if (c > 0) @(negedge PCLK);
      if (rsp_valid === 1'b1) rsps++;
      if (c == 39) cmd_valid = 1'b0;
      else if (cmd_ready === 1'b1) acc_q.push_back(c);
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge PCLK);
      if (rsp_valid === 1'b1) rsps++;
    end
    rsp_ready = 1'b0; PREADY = 1'b0;
    spacing_ok = 1;
    for (int i = 1; i < acc_q.size(); i++)
      if (acc_q[i] - acc_q[i-1] != 4) spacing_ok = 0;
    checks++;
    if (acc_q.size() != 10) $display("FAIL b2b_accepts: got %0d want 10 in 40 cycles", acc_q.size());
    else passed++;
    checks++;
    if (!spacing_ok) $display("FAIL b2b_spacing: accepts not every 4 cycles (first %0d count %0d)", acc_q[0], acc_q.size());
    else passed++;
    checks++;
    if (rsps != acc_q.size()) $display("FAIL b2b_responses: got %0d want %0d", rsps, acc_q.size());
    else passed++;
  endtask

  task automatic test_reset_mid_access();
    int acc_n;
    bit reached, quiet;
    reached = 0; acc_n = 0;
    @(negedge PCLK);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 12'h020; cmd_wdata = 16'h3C3C;
    @(posedge PCLK);
    for (int c = 1; c <= 10; c++) begin
      @(negedge PCLK);
      cmd_valid = 1'b0;
      PREADY = 1'b0;
      if (PSEL !== '0 && PENABLE === 1'b1) acc_n++;
      if (acc_n == 3) begin reached = 1; break; end
    end
    checks++;
    if (!reached) $display("FAIL rst_mid_reach: got %0d access cycles want 3", acc_n);
    else passed++;
    PRESET = 1'b1;
    @(negedge PCLK);
    PRESET = 1'b0;
    checks++;
    if ({cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, PADDR, PWRITE, PSEL, PENABLE, PWDATA} !== 53'h0)
      $display("FAIL rst_mid_outputs: got %h want 0", {cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, PADDR, PWRITE, PSEL, PENABLE, PWDATA});
    else passed++;
    quiet = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge PCLK);
      if (rsp_valid !== 1'b0 || PSEL !== '0) quiet = 0;
    end
    checks++;
    if (!quiet) $display("FAIL rst_mid_discard: got rsp_valid %b psel %b want 0 000", rsp_valid, PSEL);
    else passed++;
    do_txn("after_reset", 1'b0, 12'h40C, 16'h0, 1, 1'b0, 16'h9ABC, 0);
  endtask

  task automatic test_random();
    int r, waits;
    for (int n = 0; n < 24; n++) begin
      r = int'($urandom_range(0, 9));
      if (r < 6) waits = r % 4;
      else if (r == 6) waits = int'(TIMEOUT) - 1;
      else if (r == 7) waits = int'(TIMEOUT);
      else waits = 1 + int'($urandom_range(0, 2));
      do_txn($sformatf("rand%0d", n), 1'($urandom), 12'($urandom), 16'($urandom), waits,
             1'($urandom_range(0, 3) == 0), 16'($urandom), int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    PRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    test_reset();
    test_write_basic();
    test_read_wait();
    test_timeout();
    test_decode_err();
    test_pslverr();
    test_back_to_back();
    test_reset_mid_access();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
